// File: rtl/fpga_cfg_loader.sv
// Streaming configuration loader: assembles a word stream into a shadow register,
// verifies an XOR checksum and atomically commits it to the configuration bus.
module fpga_cfg_loader #(
   parameter int DATA_W   = 8,
   parameter int CFG_BITS = 2828
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                abort,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [DATA_W-1:0]   in_data,
   output logic [CFG_BITS-1:0] cfg_out,
   output logic                busy,
   output logic                done,
   output logic                error,
   output logic                fabric_en
);

   localparam int NWORDS = (CFG_BITS + DATA_W - 1) / DATA_W;
   localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NWORDS - 1);

   // Handshake: a word moves on any cycle with in_valid && in_ready; in_ready is
   // high exactly in LOAD and CHECK and never depends on in_valid.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      CHECK = 3'd2,
      DONE  = 3'd3,
      ERR   = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   xor_q, xor_d;
   logic [CFG_BITS-1:0] shadow_q, shadow_d;
   logic [CFG_BITS-1:0] cfg_q, cfg_d;
   logic                done_q, done_d;
   logic                error_q, error_d;
   logic                fabric_en_q, fabric_en_d;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      xor_d       = xor_q;
      shadow_d    = shadow_q;
      cfg_d       = cfg_q;
      done_d      = done_q;
      error_d     = error_q;
      fabric_en_d = fabric_en_q;
      case (state_q)
         IDLE, DONE, ERR: begin
            if (start) begin
               state_d  = LOAD;
               cnt_d    = '0;
               xor_d    = '0;
               shadow_d = '0;
               done_d   = 1'b0;
               error_d  = 1'b0;
            end
         end
         LOAD: begin
            if (abort) begin
               state_d  = ERR;
               error_d  = 1'b1;
               shadow_d = '0;
            end else if (in_valid) begin
               // Shadow is zeroed at start, so OR-in places each word; the shift
               // drops any bits of the last word beyond CFG_BITS.
               shadow_d = shadow_q | (CFG_BITS'(in_data) << (int'(cnt_q) * DATA_W));
               xor_d    = xor_q ^ in_data;
               if (cnt_q == LAST_WORD) begin
                  state_d = CHECK;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         CHECK: begin
            if (abort) begin
               state_d  = ERR;
               error_d  = 1'b1;
               shadow_d = '0;
            end else if (in_valid) begin
               if (in_data == xor_q) begin
                  state_d     = DONE;
                  cfg_d       = shadow_q;
                  done_d      = 1'b1;
                  fabric_en_d = 1'b1;
               end else begin
                  state_d = ERR;
                  error_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         xor_q       <= '0;
         shadow_q    <= '0;
         cfg_q       <= '0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         fabric_en_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         xor_q       <= xor_d;
         shadow_q    <= shadow_d;
         cfg_q       <= cfg_d;
         done_q      <= done_d;
         error_q     <= error_d;
         fabric_en_q <= fabric_en_d;
      end
   end

   assign in_ready  = (state_q == LOAD) || (state_q == CHECK);
   assign busy      = in_ready;
   assign cfg_out   = cfg_q;
   assign done      = done_q;
   assign error     = error_q;
   assign fabric_en = fabric_en_q;

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Bench for fpga_cfg_loader: directed and random loads on a 20-bit config, plus a
// full-size single-bit smoke load; outcomes are checked by a queue-based monitor.
module tb_fpga_cfg_loader;

   logic        clk = 1'b0;
   logic        rst, start, abort, in_valid;
   logic [7:0]  in_data;
   logic        in_ready, busy, done, error, fabric_en;
   logic [19:0] cfg_out;

   logic          b_start, b_abort, b_in_valid;
   logic [7:0]    b_in_data;
   logic          b_in_ready, b_busy, b_done, b_error, b_fabric_en;
   logic [2827:0] b_cfg_out;

   int n_checks = 0;
   int n_fail   = 0;

   // Expected outcome per load: {cfg_out, done, error, fabric_en}
   logic [22:0] exp_q[$];
   logic [19:0] model_cfg = '0;
   logic        model_fab = 1'b0;
   logic        prev_busy = 1'b0;

   always #5 clk = ~clk;

   fpga_cfg_loader #(.DATA_W(8), .CFG_BITS(20)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .cfg_out(cfg_out), .busy(busy), .done(done), .error(error),
      .fabric_en(fabric_en)
   );

   fpga_cfg_loader #(.DATA_W(8), .CFG_BITS(2828)) dut_big (
      .clk(clk), .rst(rst), .start(b_start), .abort(b_abort),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
      .cfg_out(b_cfg_out), .busy(b_busy), .done(b_done), .error(b_error),
      .fabric_en(b_fabric_en)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every fall of busy marks the end of a load attempt.
   always @(negedge clk) begin
      logic [22:0] e;
      if (prev_busy && !busy) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_end: busy fell with no expected outcome queued");
         end else begin
            e = exp_q.pop_front();
            check("sb_cfg_out", 32'(cfg_out), 32'(e[22:3]));
            check("sb_done", 32'(done), 32'(e[2]));
            check("sb_error", 32'(error), 32'(e[1]));
            check("sb_fabric_en", 32'(fabric_en), 32'(e[0]));
         end
      end
      prev_busy = busy;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [19:0] assemble(input logic [7:0] w0, w1, w2);
      return 20'({w2, w1, w0});
   endfunction

   task automatic push_outcome(input logic [7:0] w0, w1, w2, chk);
      if ((w0 ^ w1 ^ w2) == chk) begin
         model_cfg = assemble(w0, w1, w2);
         model_fab = 1'b1;
         exp_q.push_back({model_cfg, 1'b1, 1'b0, 1'b1});
      end else begin
         exp_q.push_back({model_cfg, 1'b0, 1'b1, model_fab});
      end
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
      check("start_in_ready", 32'(in_ready), 32'd1);
      check("start_busy", 32'(busy), 32'd1);
   endtask

   task automatic send_word(input logic [7:0] w, input int gap);
      int t;
      in_valid = 1'b0;
      repeat (gap) tick();
      in_valid = 1'b1;
      in_data  = w;
      t = 0;
      while (!in_ready && t < 20) begin
         tick();
         t++;
      end
      if (!in_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL ready_timeout: in_ready=0 after %0d cycles, required 1", t);
      end
      tick();
      in_valid = 1'b0;
   endtask

   task automatic run_load(input logic [7:0] w0, w1, w2, chk, input int gap, input bit mid_start);
      do_start();
      send_word(w0, gap);
      if (mid_start) begin
         start = 1'b1;
         tick();
         start = 1'b0;
         check("ignored_start_busy", 32'(busy), 32'd1);
      end
      send_word(w1, gap);
      send_word(w2, gap);
      push_outcome(w0, w1, w2, chk);
      send_word(chk, gap);
      check("end_in_ready", 32'(in_ready), 32'd0);
   endtask

   task automatic do_abort(input bit with_word);
      abort    = 1'b1;
      in_valid = with_word;
      in_data  = 8'($urandom);
      exp_q.push_back({model_cfg, 1'b0, 1'b1, model_fab});
      tick();
      abort    = 1'b0;
      in_valid = 1'b0;
      check("abort_in_ready", 32'(in_ready), 32'd0);
   endtask

   initial begin
      logic [7:0] w0, w1, w2, chk;
      int         k, gap;
      rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
      b_start = 1'b0; b_abort = 1'b0; b_in_valid = 1'b0; b_in_data = '0;
      repeat (2) tick();
      check("rst_cfg_out", 32'(cfg_out), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_flags", 32'({busy, done, error, fabric_en}), 32'd0);
      rst = 1'b0;

      // Valid data while idle must be ignored
      in_valid = 1'b1;
      in_data  = 8'h55;
      repeat (2) tick();
      in_valid = 1'b0;
      check("idle_in_ready", 32'(in_ready), 32'd0);
      check("idle_state", 32'({cfg_out, busy, done, error, fabric_en}), 32'd0);

      run_load(8'h01, 8'hA5, 8'h0F, 8'hAB, 0, 1'b0);
      check("good_cfg", 32'(cfg_out), 32'hFA501);
      run_load(8'h01, 8'hA5, 8'h0F, 8'h00, 2, 1'b0);
      check("bad_cfg_kept", 32'(cfg_out), 32'hFA501);

      do_start();
      send_word(8'h12, 0);
      send_word(8'h34, 1);
      do_abort(1'b0);
      run_load(8'hFF, 8'hFF, 8'h0F, 8'h0F, 0, 1'b0);
      check("ff_cfg", 32'(cfg_out), 32'hFFFFF);
      check("ff_error", 32'(error), 32'd0);

      run_load(8'h3C, 8'h81, 8'h07, 8'h3C ^ 8'h81 ^ 8'h07, 0, 1'b1);

      // Abort racing the final word: abort must win
      do_start();
      send_word(8'hAA, 0);
      send_word(8'h55, 0);
      do_abort(1'b1);

      for (int it = 0; it < 40; it++) begin
         w0  = 8'($urandom);
         w1  = 8'($urandom);
         w2  = 8'($urandom);
         chk = w0 ^ w1 ^ w2;
         if ($urandom_range(0, 1) == 0) chk = chk ^ 8'($urandom_range(1, 255));
         gap = $urandom_range(0, 2);
         if ($urandom_range(0, 5) == 0) begin
            do_start();
            k = $urandom_range(0, 3);
            for (int i = 0; i < k; i++) send_word(8'($urandom), gap);
            do_abort(1'($urandom_range(0, 1)));
         end else begin
            run_load(w0, w1, w2, chk, gap, $urandom_range(0, 3) == 0);
         end
      end

      // Reset in the middle of a load
      do_start();
      send_word(8'hC3, 0);
      rst = 1'b1;
      model_cfg = '0;
      model_fab = 1'b0;
      exp_q.push_back(23'd0);
      tick();
      rst = 1'b0;
      check("midrst_cfg", 32'(cfg_out), 32'd0);
      check("midrst_fabric_en", 32'(fabric_en), 32'd0);

      // Full-size load: only bit 0 set, checksum 0x01
      b_start = 1'b1;
      tick();
      b_start = 1'b0;
      check("big_in_ready", 32'(b_in_ready), 32'd1);
      b_in_valid = 1'b1;
      for (int i = 0; i < 354; i++) begin
         b_in_data = (i == 0) ? 8'h01 : 8'h00;
         tick();
      end
      check("big_still_busy", 32'(b_busy), 32'd1);
      b_in_data = 8'h01;
      tick();
      b_in_valid = 1'b0;
      check("big_done", 32'(b_done), 32'd1);
      check("big_error", 32'(b_error), 32'd0);
      check("big_fabric_en", 32'(b_fabric_en), 32'd1);
      check("big_bit0", 32'(b_cfg_out[0]), 32'd1);
      check("big_upper_zero", 32'(b_cfg_out[2827:1] == '0), 32'd1);

      repeat (3) tick();
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fpga_cfg_loader.md
# fpga_cfg_loader

Streaming configuration loader for `fpga_top`. It accepts the fabric bitstream as a valid/ready word stream and assembles it into a shadow register. It verifies an XOR checksum, then atomically commits the result to the flat configuration bus. That bus drives `brbselect`, `bsbselect`, `lbselect` and the four `*ioselect` vectors. It replaces testbench-side direct poking of select vectors, and generalises to any fabric size and input word width.

## Interface
- `DATA_W`, 8: input word width in bits; must be at least 1.
- `CFG_BITS`, 2828: total configuration bits. The default covers the 3×5×5 fabric: 900 + 1728 + 80 + 4×30.
- `NWORDS`, derived: equals ceil(`CFG_BITS`/`DATA_W`) payload words.

Ports:
- `clk`, input, 1: single clock; all logic is on the rising edge.
- `rst`, input, 1: synchronous reset, active-high.
- `start`, input, 1: one-cycle pulse that begins a load. It is honoured in IDLE, DONE and ERR and ignored elsewhere.
- `abort`, input, 1: abandons a load in progress.
- `in_valid`, input, 1: `in_data` is valid this cycle.
- `in_ready`, output, 1: the loader accepts a word this cycle.
- `in_data`, input, `DATA_W`: payload or checksum word.
- `cfg_out`, output, `CFG_BITS`: active configuration bus; bit 0 maps to `brbselect[0]`.
- `busy`, output, 1: high in LOAD and CHECK.
- `done`, output, 1: last load committed successfully.
- `error`, output, 1: last load failed its checksum or was aborted.
- `fabric_en`, output, 1: at least one configuration has been committed since reset.

## Operation
- **States:** IDLE, LOAD, CHECK, DONE, ERR.
- **Transfer rule:** a word transfers on a cycle where `in_valid && in_ready`. `in_ready` is 1 only in LOAD and CHECK.
- **IDLE → LOAD on `start`:** word counter ← 0, running XOR ← 0, shadow register ← 0.
- **Transfers in LOAD:**
  - Word k is written to shadow bits [k·DATA_W +: DATA_W], LSB-first.
  - Bits at or above `CFG_BITS` in the last word are discarded but still included in the XOR.
  - Running XOR ← XOR ^ `in_data`.
  - On the transfer of word `NWORDS`−1, go to CHECK.
- **Single transfer in CHECK:**
  - If `in_data` equals the running XOR: `cfg_out` ← shadow, `done` ← 1, `fabric_en` ← 1, go to DONE.
  - Otherwise: `error` ← 1, go to ERR, and `cfg_out` is left unchanged.
- **DONE and ERR:** these hold until `start`, which re-enters LOAD with the same initialisation as from IDLE.
- **Clearing flags:** `done` and `error` both clear on the accepted `start`.
- **`abort` in LOAD or CHECK:** go to ERR with `error` = 1. `cfg_out` is unchanged and the shadow contents are discarded.
- **`abort` in any other state:** no effect.
- **Priority:** `abort` beats a simultaneous word transfer, so that word is not consumed for checksum purposes.
- **`start` while busy:** ignored and does not restart the load.
- **`fabric_en`:** once set, it only clears on `rst`. A failed reload keeps the previously committed configuration live.

## Timing
- **Reset values:** state = IDLE, `cfg_out` = 0, `in_ready` = 0, `busy` = 0, `done` = 0, `error` = 0, `fabric_en` = 0. The counter, XOR and shadow are all cleared.
- **Reset mid-load:** behaves identically to reset from IDLE; the partial load is discarded.
- **Start to ready:** `start` sampled at edge t gives `in_ready` = 1 and `busy` = 1 from t+1.
- **Throughput:** one word per cycle. A stall (`in_valid` = 0) holds all state.
- **Load length:** a full load takes at least `NWORDS`+1 transfer cycles.
- **Commit timing:**
  - `cfg_out`, `done` and `fabric_en` update at the edge that accepts the checksum and are visible the next cycle.
  - `in_ready` and `busy` drop in that same cycle.
- **Glitch-free output:** `cfg_out` never shows partial data. It changes only on commit or `rst`.
- **`NWORDS` = 1:** LOAD holds exactly one transfer, then CHECK.

## Test plan
All scenarios use `DATA_W`=8 and `CFG_BITS`=20, so `NWORDS`=3.

1. **Reset state:** assert `rst` for 2 cycles → all outputs 0 and `in_ready` = 0. Drive `in_valid` = 1 while IDLE → no effect.
2. **Good load:** `start`, then 0x01, 0xA5, 0x0F, checksum 0xAB → `done` = 1, `fabric_en` = 1 and `cfg_out` = 20'hFA501. The upper nibble of 0x0F is discarded.
3. **Stalls and bad checksum:** load 0x01, 0xA5, 0x0F with 2-cycle `in_valid` gaps → no extra words taken. Then checksum 0x00 → `error` = 1, `done` = 0 and `cfg_out` stays 20'hFA501.
4. **Abort mid-load:** abort after 2 words → ERR. A fresh `start` with 0xFF, 0xFF, 0x0F, checksum 0x0F → `cfg_out` = 20'hFFFFF and `error` = 0.
5. **Ignored start / `rst` mid-load:** pulse `start` while in LOAD → ignored and the word count continues. Assert `rst` after 1 word → `cfg_out` = 0 and `fabric_en` = 0.
6. **Full-size smoke test:** default parameters with a bitstream whose only set bit is bit 0 (`brbselect[0]`), wired to `fpga_top` → after commit, `cfg_out[0]` = 1 and all other bits are 0.
